// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multicycle control FSM and ALUControl
package ctrl_pkg;

  // FSM state encoding (also exported on the debug state output)
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  // Primary opcodes, instruction bits [31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // alu_op codes understood by ALUControl
  localparam logic [3:0] ALU_NONE  = 4'b0000;
  localparam logic [3:0] ALU_ADD   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_BEQ   = 4'b0101;
  localparam logic [3:0] ALU_BNE   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SLTU  = 4'b1000;
  localparam logic [3:0] ALU_LUI   = 4'b1001;
  localparam logic [3:0] ALU_LW    = 4'b1010;
  localparam logic [3:0] ALU_SW    = 4'b1011;
  localparam logic [3:0] ALU_J     = 4'b1100;
  localparam logic [3:0] ALU_JAL   = 4'b1101;
  localparam logic [3:0] ALU_RTYPE = 4'b1111;

  // Datapath mux selects
  localparam logic       SRCA_PC      = 1'b0;
  localparam logic       SRCA_RS      = 1'b1;
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_SHL2    = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] REGDST_RT    = 2'b00;
  localparam logic [1:0] REGDST_RD    = 2'b01;
  localparam logic [1:0] REGDST_R31   = 2'b10;
  localparam logic [1:0] M2R_ALUOUT   = 2'b00;
  localparam logic [1:0] M2R_MEM      = 2'b01;
  localparam logic [1:0] M2R_PC       = 2'b10;
  localparam logic [1:0] M2R_LUI      = 2'b11;

  // R-type funct values the datapath implements
  function automatic logic funct_is_legal(input logic [5:0] fn);
    logic ok;
    case (fn)
      6'd0, 6'd2, 6'd3, 6'd32, 6'd34, 6'd36,
      6'd37, 6'd38, 6'd39, 6'd42, 6'd43: ok = 1'b1;
      default:                           ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control bus between the FSM and the datapath (MULTICYCLE_PERF_CNT_EN adds counters)
interface multicycle_control_if;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic [3:0]  alu_op;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  pc_src;
  logic        pc_write;
  logic        ir_write;
  logic        iord;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic [1:0]  reg_dst;
  logic [1:0]  mem_to_reg;
  logic        illegal;
  logic [2:0]  state;
`ifdef MULTICYCLE_PERF_CNT_EN
  logic [31:0] cycle_count;
  logic [31:0] instr_count;
`endif

  modport master (
    input  opcode, funct, zero, mem_ready,
    output alu_op, alu_src_a, alu_src_b, pc_src, pc_write, ir_write, iord,
           mem_read, mem_write, reg_write, reg_dst, mem_to_reg, illegal, state
`ifdef MULTICYCLE_PERF_CNT_EN
    , output cycle_count, instr_count
`endif
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  alu_op, alu_src_a, alu_src_b, pc_src, pc_write, ir_write, iord,
           mem_read, mem_write, reg_write, reg_dst, mem_to_reg, illegal, state
`ifdef MULTICYCLE_PERF_CNT_EN
    , input cycle_count, instr_count
`endif
  );

endinterface

// File: rtl/op_to_aluop.sv
// rtl/op_to_aluop.sv - maps latched opcode/funct to the ALUControl code and a legality bit
module op_to_aluop
  import ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] fn_i,
  output logic [3:0] alu_op_o,
  output logic       legal_o
);

  // Opcode lookup; anything not listed is an illegal instruction
  always_comb begin
    alu_op_o = ALU_NONE;
    legal_o  = 1'b1;
    case (op_i)
      OP_RTYPE: begin
        alu_op_o = ALU_RTYPE;
        legal_o  = funct_is_legal(fn_i);
      end
      OP_ADDI:  alu_op_o = ALU_ADD;
      OP_ANDI:  alu_op_o = ALU_AND;
      OP_ORI:   alu_op_o = ALU_OR;
      OP_XORI:  alu_op_o = ALU_XOR;
      OP_BEQ:   alu_op_o = ALU_BEQ;
      OP_BNE:   alu_op_o = ALU_BNE;
      OP_SLTI:  alu_op_o = ALU_SLT;
      OP_SLTIU: alu_op_o = ALU_SLTU;
      OP_LUI:   alu_op_o = ALU_LUI;
      OP_LW:    alu_op_o = ALU_LW;
      OP_SW:    alu_op_o = ALU_SW;
      OP_J:     alu_op_o = ALU_J;
      OP_JAL:   alu_op_o = ALU_JAL;
      default:  legal_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle main control FSM (MULTICYCLE_PERF_CNT_EN adds perf counters)
module multicycle_control
  import ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  state_e     state_q, state_d;
  logic [5:0] op_q, fn_q;
  logic       illegal_q;
  logic [3:0] map_alu_op;
  logic       map_legal;

  logic [3:0] alu_op_c;
  logic       alu_src_a_c;
  logic [1:0] alu_src_b_c, pc_src_c, reg_dst_c, mem_to_reg_c;
  logic       pc_write_c, ir_write_c, iord_c, mem_read_c, mem_write_c, reg_write_c;

  op_to_aluop u_op_to_aluop (
    .op_i     (op_q),
    .fn_i     (fn_q),
    .alu_op_o (map_alu_op),
    .legal_o  (map_legal)
  );

  // State, latched instruction fields and sticky trap flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      op_q      <= 6'd0;
      fn_q      <= 6'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && bus.mem_ready) begin
        op_q <= bus.opcode;
        fn_q <= bus.funct;
      end
      if (state_d == S_TRAP) illegal_q <= 1'b1;
    end
  end

  // Next state and per-state datapath controls
  always_comb begin
    state_d      = state_q;
    alu_op_c     = ALU_NONE;
    alu_src_a_c  = SRCA_PC;
    alu_src_b_c  = SRCB_RT;
    pc_src_c     = PCSRC_ALU;
    pc_write_c   = 1'b0;
    ir_write_c   = 1'b0;
    iord_c       = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    reg_write_c  = 1'b0;
    reg_dst_c    = REGDST_RT;
    mem_to_reg_c = M2R_ALUOUT;
    case (state_q)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = SRCB_FOUR;
        alu_op_c    = ALU_ADD;
        ir_write_c  = bus.mem_ready;
        pc_write_c  = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b_c = SRCB_SHL2;
        alu_op_c    = ALU_ADD;
        state_d     = map_legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        alu_op_c = map_alu_op;
        case (op_q)
          OP_LW, OP_SW: begin
            alu_src_a_c = SRCA_RS;
            alu_src_b_c = SRCB_IMM;
            state_d     = S_MEM;
          end
          OP_BEQ, OP_BNE: begin
            alu_src_a_c = SRCA_RS;
            alu_src_b_c = SRCB_RT;
            pc_src_c    = PCSRC_ALUOUT;
            pc_write_c  = (op_q == OP_BEQ) ? bus.zero : ~bus.zero;
            state_d     = S_FETCH;
          end
          OP_J: begin
            pc_src_c   = PCSRC_JUMP;
            pc_write_c = 1'b1;
            state_d    = S_FETCH;
          end
          OP_JAL: begin
            pc_src_c     = PCSRC_JUMP;
            pc_write_c   = 1'b1;
            reg_write_c  = 1'b1;
            reg_dst_c    = REGDST_R31;
            mem_to_reg_c = M2R_PC;
            state_d      = S_FETCH;
          end
          default: begin
            alu_src_a_c = SRCA_RS;
            alu_src_b_c = (op_q == OP_RTYPE) ? SRCB_RT : SRCB_IMM;
            state_d     = S_WB;
          end
        endcase
      end
      S_MEM: begin
        alu_op_c = map_alu_op;
        iord_c   = 1'b1;
        if (op_q == OP_LW) begin
          mem_read_c = 1'b1;
          if (bus.mem_ready) state_d = S_WB;
        end else begin
          mem_write_c = 1'b1;
          if (bus.mem_ready) state_d = S_FETCH;
        end
      end
      S_WB: begin
        alu_op_c     = map_alu_op;
        reg_write_c  = 1'b1;
        reg_dst_c    = (op_q == OP_RTYPE) ? REGDST_RD : REGDST_RT;
        mem_to_reg_c = (op_q == OP_LW)  ? M2R_MEM :
                       (op_q == OP_LUI) ? M2R_LUI : M2R_ALUOUT;
        state_d      = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are gated by rst_n so nothing writes while reset is held
  assign bus.pc_write   = pc_write_c  & rst_n;
  assign bus.ir_write   = ir_write_c  & rst_n;
  assign bus.reg_write  = reg_write_c & rst_n;
  assign bus.mem_read   = mem_read_c  & rst_n;
  assign bus.mem_write  = mem_write_c & rst_n;
  assign bus.iord       = iord_c;
  assign bus.alu_op     = alu_op_c;
  assign bus.alu_src_a  = alu_src_a_c;
  assign bus.alu_src_b  = alu_src_b_c;
  assign bus.pc_src     = pc_src_c;
  assign bus.reg_dst    = reg_dst_c;
  assign bus.mem_to_reg = mem_to_reg_c;
  assign bus.illegal    = illegal_q;
  assign bus.state      = state_q;

`ifdef MULTICYCLE_PERF_CNT_EN
  logic [31:0] cycle_count_q, instr_count_q;

  // Cycle and retired-instruction counters, wrapping at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count_q <= 32'd0;
      instr_count_q <= 32'd0;
    end else begin
      if (state_q != S_TRAP) cycle_count_q <= cycle_count_q + 32'd1;
      if (state_d == S_FETCH &&
          (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB))
        instr_count_q <= instr_count_q + 32'd1;
    end
  end

  assign bus.cycle_count = cycle_count_q;
  assign bus.instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for the multicycle control FSM
module tb_multicycle_control;

  typedef struct packed {
    logic [2:0] state;
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       illegal;
  } ctl_t;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic       rdy;
    logic       z;
    ctl_t       e;
  } item_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  int    checks = 0;
  int    failures = 0;
  item_t sb[$];

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no summary, expected completion");
    $fatal(1, "timeout");
  end

  function automatic ctl_t mk(int st, int aop, int a, int b, int pcs, int pcw, int irw,
                              int iord, int mr, int mw, int rw, int rd, int m2r, int ill);
    ctl_t r;
    r.state = st[2:0];      r.alu_op = aop[3:0];     r.alu_src_a = a[0];
    r.alu_src_b = b[1:0];   r.pc_src = pcs[1:0];     r.pc_write = pcw[0];
    r.ir_write = irw[0];    r.iord = iord[0];        r.mem_read = mr[0];
    r.mem_write = mw[0];    r.reg_write = rw[0];     r.reg_dst = rd[1:0];
    r.mem_to_reg = m2r[1:0]; r.illegal = ill[0];
    return r;
  endfunction

  function automatic ctl_t fetch_e(int r);
    return mk(0, 1, 0, 1, 0, r, r, 0, 1, 0, 0, 0, 0, 0);
  endfunction

  function automatic ctl_t decode_e();
    return mk(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic ctl_t reset_e();
    return mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic ctl_t sample();
    ctl_t s;
    s.state = bus.state;         s.alu_op = bus.alu_op;     s.alu_src_a = bus.alu_src_a;
    s.alu_src_b = bus.alu_src_b; s.pc_src = bus.pc_src;     s.pc_write = bus.pc_write;
    s.ir_write = bus.ir_write;   s.iord = bus.iord;         s.mem_read = bus.mem_read;
    s.mem_write = bus.mem_write; s.reg_write = bus.reg_write; s.reg_dst = bus.reg_dst;
    s.mem_to_reg = bus.mem_to_reg; s.illegal = bus.illegal;
    return s;
  endfunction

  task automatic push(input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                      input logic z, input ctl_t e);
    item_t it;
    it.op = op; it.fn = fn; it.rdy = rdy; it.z = z; it.e = e;
    sb.push_back(it);
  endtask

  task automatic test_reset();
    ctl_t obs;
    bus.opcode = 6'h00; bus.funct = 6'd32; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    obs = sample();
    checks++;
    if (obs !== reset_e()) begin
      failures++;
      $display("FAIL reset_hold: got %h, expected %h", obs, reset_e());
    end
    bus.mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    obs = sample();
    checks++;
    if (obs !== fetch_e(0)) begin
      failures++;
      $display("FAIL reset_first_fetch: got %h, expected %h", obs, fetch_e(0));
    end
  endtask

  task automatic test_add();
    item_t it; ctl_t obs; int cyc = 0;
    push(6'h00, 6'd32, 1'b1, 1'b0, fetch_e(1));
    push(6'h00, 6'd32, 1'b1, 1'b0, decode_e());
    push(6'h00, 6'd32, 1'b1, 1'b0, mk(2, 15, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(6'h00, 6'd32, 1'b1, 1'b0, mk(4, 15, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    push(6'h00, 6'd32, 1'b0, 1'b0, fetch_e(0));
    while (sb.size() != 0) begin
      it = sb.pop_front();
      @(negedge clk);
      bus.opcode = it.op; bus.funct = it.fn; bus.mem_ready = it.rdy; bus.zero = it.z;
      #1;
      obs = sample();
      checks++;
      if (obs !== it.e) begin
        failures++;
        $display("FAIL add cycle %0d: got %h, expected %h", cyc, obs, it.e);
      end
      cyc++;
    end
  endtask

  task automatic test_lw_wait();
    item_t it; ctl_t obs; int cyc = 0;
    push(6'h23, 6'd0, 1'b1, 1'b0, fetch_e(1));
    push(6'h23, 6'd0, 1'b1, 1'b0, decode_e());
    push(6'h23, 6'd0, 1'b1, 1'b0, mk(2, 10, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(6'h23, 6'd0, 1'b0, 1'b0, mk(3, 10, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    push(6'h23, 6'd0, 1'b0, 1'b0, mk(3, 10, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    push(6'h23, 6'd0, 1'b1, 1'b0, mk(3, 10, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    push(6'h23, 6'd0, 1'b1, 1'b0, mk(4, 10, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    push(6'h23, 6'd0, 1'b0, 1'b0, fetch_e(0));
    while (sb.size() != 0) begin
      it = sb.pop_front();
      @(negedge clk);
      bus.opcode = it.op; bus.funct = it.fn; bus.mem_ready = it.rdy; bus.zero = it.z;
      #1;
      obs = sample();
      checks++;
      if (obs !== it.e) begin
        failures++;
        $display("FAIL lw_wait cycle %0d: got %h, expected %h", cyc, obs, it.e);
      end
      cyc++;
    end
  endtask

  task automatic test_branch();
    item_t it; ctl_t obs; int cyc = 0;
    logic [5:0] ops [4];
    int zs [4];
    int pcw [4];
    ops[0] = 6'h04; zs[0] = 1; pcw[0] = 1;
    ops[1] = 6'h04; zs[1] = 0; pcw[1] = 0;
    ops[2] = 6'h05; zs[2] = 1; pcw[2] = 0;
    ops[3] = 6'h05; zs[3] = 0; pcw[3] = 1;
    for (int i = 0; i < 4; i++) begin
      push(ops[i], 6'd0, 1'b1, zs[i][0], fetch_e(1));
      push(ops[i], 6'd0, 1'b1, zs[i][0], decode_e());
      push(ops[i], 6'd0, 1'b1, zs[i][0],
           mk(2, (ops[i] == 6'h04) ? 5 : 6, 1, 0, 1, pcw[i], 0, 0, 0, 0, 0, 0, 0, 0));
    end
    push(6'h00, 6'd0, 1'b0, 1'b0, fetch_e(0));
    while (sb.size() != 0) begin
      it = sb.pop_front();
      @(negedge clk);
      bus.opcode = it.op; bus.funct = it.fn; bus.mem_ready = it.rdy; bus.zero = it.z;
      #1;
      obs = sample();
      checks++;
      if (obs !== it.e) begin
        failures++;
        $display("FAIL branch cycle %0d: got %h, expected %h", cyc, obs, it.e);
      end
      cyc++;
    end
  endtask

  task automatic test_jal();
    item_t it; ctl_t obs; int cyc = 0;
    push(6'h03, 6'd0, 1'b1, 1'b0, fetch_e(1));
    push(6'h03, 6'd0, 1'b1, 1'b0, decode_e());
    push(6'h03, 6'd0, 1'b1, 1'b0, mk(2, 13, 0, 0, 2, 1, 0, 0, 0, 0, 1, 2, 2, 0));
    push(6'h03, 6'd0, 1'b0, 1'b0, fetch_e(0));
    while (sb.size() != 0) begin
      it = sb.pop_front();
      @(negedge clk);
      bus.opcode = it.op; bus.funct = it.fn; bus.mem_ready = it.rdy; bus.zero = it.z;
      #1;
      obs = sample();
      checks++;
      if (obs !== it.e) begin
        failures++;
        $display("FAIL jal cycle %0d: got %h, expected %h", cyc, obs, it.e);
      end
      cyc++;
    end
  endtask

  task automatic test_back_to_back();
    item_t it; ctl_t obs; int cyc = 0;
    push(6'h2B, 6'd0, 1'b1, 1'b0, fetch_e(1));
    push(6'h2B, 6'd0, 1'b1, 1'b0, decode_e());
    push(6'h2B, 6'd0, 1'b1, 1'b0, mk(2, 11, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(6'h2B, 6'd0, 1'b1, 1'b0, mk(3, 11, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    push(6'h0D, 6'd0, 1'b1, 1'b0, fetch_e(1));
    push(6'h0D, 6'd0, 1'b1, 1'b0, decode_e());
    push(6'h0D, 6'd0, 1'b1, 1'b0, mk(2, 3, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(6'h0D, 6'd0, 1'b1, 1'b0, mk(4, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    push(6'h0F, 6'd0, 1'b1, 1'b0, fetch_e(1));
    push(6'h0F, 6'd0, 1'b1, 1'b0, decode_e());
    push(6'h0F, 6'd0, 1'b1, 1'b0, mk(2, 9, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(6'h0F, 6'd0, 1'b1, 1'b0, mk(4, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0));
    push(6'h0F, 6'd0, 1'b0, 1'b0, fetch_e(0));
    while (sb.size() != 0) begin
      it = sb.pop_front();
      @(negedge clk);
      bus.opcode = it.op; bus.funct = it.fn; bus.mem_ready = it.rdy; bus.zero = it.z;
      #1;
      obs = sample();
      checks++;
      if (obs !== it.e) begin
        failures++;
        $display("FAIL back_to_back cycle %0d: got %h, expected %h", cyc, obs, it.e);
      end
      cyc++;
    end
  endtask

  task automatic test_trap(input logic [5:0] op, input logic [5:0] fn);
    item_t it; ctl_t obs; int cyc = 0;
    push(op, fn, 1'b1, 1'b0, fetch_e(1));
    push(op, fn, 1'b1, 1'b0, decode_e());
    for (int i = 0; i < 10; i++)
      push(op, fn, 1'b1, 1'b1, mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    while (sb.size() != 0) begin
      it = sb.pop_front();
      @(negedge clk);
      bus.opcode = it.op; bus.funct = it.fn; bus.mem_ready = it.rdy; bus.zero = it.z;
      #1;
      obs = sample();
      checks++;
      if (obs !== it.e) begin
        failures++;
        $display("FAIL trap op %h fn %0d cycle %0d: got %h, expected %h", op, fn, cyc, obs, it.e);
      end
      cyc++;
    end
    @(negedge clk);
    bus.mem_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    obs = sample();
    checks++;
    if (obs !== fetch_e(0)) begin
      failures++;
      $display("FAIL trap_clear op %h: got %h, expected %h", op, obs, fetch_e(0));
    end
  endtask

  task automatic test_sw_reset();
    item_t it; ctl_t obs; int cyc = 0;
    push(6'h2B, 6'd0, 1'b1, 1'b0, fetch_e(1));
    push(6'h2B, 6'd0, 1'b1, 1'b0, decode_e());
    push(6'h2B, 6'd0, 1'b1, 1'b0, mk(2, 11, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(6'h2B, 6'd0, 1'b0, 1'b0, mk(3, 11, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    while (sb.size() != 0) begin
      it = sb.pop_front();
      @(negedge clk);
      bus.opcode = it.op; bus.funct = it.fn; bus.mem_ready = it.rdy; bus.zero = it.z;
      #1;
      obs = sample();
      checks++;
      if (obs !== it.e) begin
        failures++;
        $display("FAIL sw_reset cycle %0d: got %h, expected %h", cyc, obs, it.e);
      end
      cyc++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    obs = sample();
    checks++;
    if (obs !== reset_e()) begin
      failures++;
      $display("FAIL sw_reset_assert: got %h, expected %h", obs, reset_e());
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    obs = sample();
    checks++;
    if (obs !== fetch_e(0)) begin
      failures++;
      $display("FAIL sw_reset_release: got %h, expected %h", obs, fetch_e(0));
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_jal();
    test_back_to_back();
    test_trap(6'h3F, 6'd0);
    test_trap(6'h00, 6'd5);
    test_sw_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
